// File: rtl/ppm_pkg.sv
// Shared types and helpers for the code-to-PPM pulse generator.
package ppm_pkg;

  localparam int unsigned CODE_W = 16;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Keeps every pulse at least one cycle shorter than the frame.
  function automatic code_t clamp_code(input code_t code, input code_t period);
    code_t lim;
    lim = period - code_t'(2);
    return (code > lim) ? lim : code;
  endfunction

endpackage

// File: rtl/ppm_chan.sv
// One PPM channel: double-buffered code with write-side clamp and load forwarding.
module ppm_chan
  import ppm_pkg::*;
#(
  parameter logic [15:0] PERIOD    = 16'd60000,
  parameter logic [15:0] INIT_CODE = 16'd2999
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        we,
  input  logic [15:0] code,
  input  logic        load,
  input  logic [15:0] frame_cnt,
  input  logic        run,
  output logic        pulse
);

  code_t pending;
  code_t shadow;
  code_t code_c;

  assign code_c = clamp_code(code, PERIOD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= INIT_CODE;
      shadow  <= INIT_CODE;
      pulse   <= 1'b0;
    end else begin
      if (we) begin
        pending <= code_c;
      end
      // A write coinciding with a frame-boundary load bypasses pending.
      if (load) begin
        shadow <= we ? code_c : pending;
      end
      pulse <= run && (frame_cnt <= shadow);
    end
  end

endmodule

// File: rtl/code_to_ppm.sv
// Multi-channel PPM pulse generator: shared frame timebase, per-channel pulse width CODE+1.
module code_to_ppm
  import ppm_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter logic [15:0] PERIOD    = 16'd60000,
  parameter logic [15:0] INIT_CODE = 16'd2999
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [16*NCH-1:0] CODE,
  input  logic [NCH-1:0]    CODE_WE,
  output logic [NCH-1:0]    PPM,
  output logic              FRAME_SYNC,
  output logic              ACTIVE
);

  state_t state;
  state_t state_nx;
  code_t  frame_cnt;
  code_t  cnt_nx;
  logic   run;
  logic   wrap;
  logic   load;

  assign run  = (state == RUN);
  assign wrap = run && (frame_cnt == PERIOD - 16'd1);

  always_comb begin
    state_nx = state;
    cnt_nx   = frame_cnt;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (EN) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_nx = '0;
          load   = 1'b1;
          if (!EN) begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = frame_cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      FRAME_SYNC <= 1'b0;
      ACTIVE     <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_cnt  <= cnt_nx;
      FRAME_SYNC <= run && (frame_cnt == '0);
      ACTIVE     <= run;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ppm_chan #(
      .PERIOD   (PERIOD),
      .INIT_CODE(INIT_CODE)
    ) u_chan (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .we       (CODE_WE[i]),
      .code     (CODE[16*i +: 16]),
      .load     (load),
      .frame_cnt(frame_cnt),
      .run      (run),
      .pulse    (PPM[i])
    );
  end

endmodule
